ulpb_rx_fifo: RTL and testbench
===============================

Name: ulpb_rx_fifo

Overview:
Parametrised receive buffer between a ulpb node's RX handshake port and the layer logic. It performs the node-side 4-phase REQ_RX/ACK_RX handshake on its own. Each received (address, data) word is stored in a DEPTH-entry first-word-fall-through FIFO, which the layer drains with a valid/ready pop interface. When the FIFO is full, the block either withholds ACK_RX (backpressure, so the sender eventually sees TX_FAIL) or acknowledges and drops the word with a sticky overflow flag, selected by DROP_ON_FULL.

Parameters:
ADDR_WIDTH, 8, width of the received address field
DATA_WIDTH, 32, width of one received data word
DEPTH, 4, number of FIFO entries; power of two, >= 2
DROP_ON_FULL, 0, 0 = stall handshake while full; 1 = ack and discard while full
ALMOST_FULL_LVL, 3, ALMOST_FULL asserts when COUNT >= this value; legal range 1..DEPTH

Ports:
CLK  input  1  bus clock (SCLK domain of the attached node)
RESET  input  1  asynchronous, active-low reset
REQ_RX  input  1  node request: word present on RX_ADDR/RX_DATA
ACK_RX  output  1  acknowledge to node
RX_ADDR  input  ADDR_WIDTH  node ADDR_OUT
RX_DATA  input  DATA_WIDTH  node DATA_OUT
POP_VALID  output  1  head entry valid (FIFO not empty)
POP_READY  input  1  layer consumes head entry
POP_ADDR  output  ADDR_WIDTH  head entry address
POP_DATA  output  DATA_WIDTH  head entry data
COUNT  output  clog2(DEPTH+1)  occupied entries
FULL  output  1  COUNT == DEPTH
ALMOST_FULL  output  1  COUNT >= ALMOST_FULL_LVL
OVERFLOW  output  1  sticky: a word was dropped (DROP_ON_FULL=1 only)
CLR_OVF  input  1  synchronous clear of OVERFLOW

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, pointers 0, COUNT=0, ACK_RX=0, POP_VALID=0, FULL=0, ALMOST_FULL=0, OVERFLOW=0. POP_ADDR/POP_DATA are 0 at reset; otherwise they reflect the head entry.
- Handshake FSM states: IDLE, ACK, STALL. All outputs are registered.
- IDLE, REQ_RX=1, FULL=0: write {RX_ADDR, RX_DATA} at wr_ptr and set ACK_RX=1 on the same edge. Next state ACK.
- IDLE, REQ_RX=1, FULL=1, DROP_ON_FULL=0: next state STALL, ACK_RX stays 0.
- IDLE, REQ_RX=1, FULL=1, DROP_ON_FULL=1: discard the word, set OVERFLOW=1 and ACK_RX=1. Next state ACK.
- STALL: once FULL=0 (registered value), capture as in IDLE and go to ACK. If REQ_RX falls while in STALL (node abandoned the word), return to IDLE with no write.
- ACK: hold ACK_RX=1 until REQ_RX=0, then ACK_RX=0 on that edge and go to IDLE. A new REQ_RX is therefore seen no earlier than one cycle after ACK_RX falls.
- Exactly one FIFO write per REQ_RX assertion. A REQ_RX held high in ACK is never re-captured.
- Pop: the edge with POP_VALID & POP_READY advances rd_ptr. POP_READY while empty is ignored.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance. When full, a same-cycle pop does not enable a push on that edge; the push happens on the next edge. This costs one cycle of latency and keeps the full decision purely registered.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. COUNT is maintained explicitly and never exceeds DEPTH or goes below 0.
- CLR_OVF has priority over a same-cycle drop: OVERFLOW ends the cycle at 0, and that drop is lost from the flag.
- Data path width: the stored entry is ADDR_WIDTH+DATA_WIDTH bits, with the address in the MSBs.

Decomposition:
- Shared package ulpb_pkg: the FSM state encodings (IDLE=2'd0, ACK=2'd1, STALL=2'd2) and the default ADDR_WIDTH/DATA_WIDTH constants shared with ulpb_node32.
- One sub-module, ulpb_fifo_mem: storage array, wr/rd pointers, COUNT, FULL/EMPTY/ALMOST_FULL. It exposes push/pop strobes only. The handshake FSM and OVERFLOW stay in ulpb_rx_fifo.

Test Plan:
1. Single word, POP_READY=1: REQ_RX with 0xab/0xabcdef12 -> ACK_RX rises 1 cycle later; POP_VALID=1 with POP_ADDR=0xab, POP_DATA=0xabcdef12; COUNT returns 0 after the pop.
2. Fill and wrap, DEPTH=4, POP_READY=0: push 6 words 0x21fedcba..+5 with DROP_ON_FULL=0 -> FULL after 4 words and ALMOST_FULL after 3; the 5th REQ_RX sits in STALL with ACK_RX=0. Pop one -> the 5th is acked two edges later. Pop all -> data in order and pointers wrapped.
3. Drop mode, DROP_ON_FULL=1, full FIFO: push 0xaabbccdd -> ACK_RX asserts, OVERFLOW=1, COUNT stays 4, and contents are unchanged. CLR_OVF pulse -> OVERFLOW=0.
4. Stall abandon: FIFO full, REQ_RX high 20 cycles then low -> no write, state IDLE, ACK_RX never asserts.
5. Simultaneous push/pop at COUNT=2 -> COUNT stays 2 and the popped/pushed data sequence is correct. CLR_OVF and a drop in the same cycle -> OVERFLOW=0.
6. Reset mid-operation: RESET low during ACK with COUNT=3 -> ACK_RX=0, COUNT=0, POP_VALID=0 immediately (asynchronously). After release, a new word 0x55667788 is captured normally.

Source files
------------

// File: rtl/ulpb_pkg.sv
// ulpb_pkg: constants and FSM state encodings shared by the ulpb RX path and ulpb_node32.
// Contents:
//   ULPB_ADDR_WIDTH / ULPB_DATA_WIDTH - default address and data field widths
//   rx_state_t                        - RX handshake FSM states
package ulpb_pkg;
    localparam int ULPB_ADDR_WIDTH = 8;
    localparam int ULPB_DATA_WIDTH = 32;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        STALL = 2'd2
    } rx_state_t;
endpackage

// File: rtl/ulpb_fifo_mem.sv
// ulpb_fifo_mem: first-word-fall-through FIFO storage with registered occupancy flags.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push, wdata       - write strobe and entry (ignored while full)
//   pop               - advance head (ignored while empty)
//   rdata             - head entry (reset contents are zero)
//   count             - occupied entries
//   full, empty       - count == DEPTH, count == 0
//   almost_full       - count >= AF_LVL
module ulpb_fifo_mem
    import ulpb_pkg::*;
#(
    parameter int WIDTH  = ULPB_ADDR_WIDTH + ULPB_DATA_WIDTH,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push_en, pop_en;
    assign push_en   = push & ~full;
    assign pop_en    = pop & ~empty;
    assign count_nxt = count + CW'(push_en) - CW'(pop_en);
    assign rdata     = mem[rd_ptr];
    // Flags are registered from the next count so downstream decisions see only flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            full        <= count_nxt == FULL_C;
            empty       <= count_nxt == '0;
            almost_full <= count_nxt >= AF_C;
        end
    end
endmodule

// File: rtl/ulpb_rx_fifo.sv
// ulpb_rx_fifo: ulpb node RX handshake responder feeding a FWFT FIFO drained by valid/ready.
// Ports:
//   clk, rst_n            - bus clock, asynchronous active-low reset
//   req_rx, ack_rx        - 4-phase handshake with the node
//   rx_addr, rx_data      - word offered by the node
//   pop_valid, pop_ready  - head entry valid / consumed by layer logic
//   pop_addr, pop_data    - head entry
//   count, full, almost_full - occupancy
//   overflow, clr_ovf     - sticky drop flag (DROP_ON_FULL=1) and its synchronous clear
module ulpb_rx_fifo
    import ulpb_pkg::*;
#(
    parameter int ADDR_WIDTH      = ULPB_ADDR_WIDTH,
    parameter int DATA_WIDTH      = ULPB_DATA_WIDTH,
    parameter int DEPTH           = 4,
    parameter int DROP_ON_FULL    = 0,
    parameter int ALMOST_FULL_LVL = 3,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rx,
    output logic                  ack_rx,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [ADDR_WIDTH-1:0] pop_addr,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_ovf
);
    localparam int W = ADDR_WIDTH + DATA_WIDTH;
    rx_state_t  state, state_nxt;
    logic       ack_nxt, ovf_nxt, push, drop, empty;
    logic [W-1:0] rdata;
    ulpb_fifo_mem #(.WIDTH(W), .DEPTH(DEPTH), .AF_LVL(ALMOST_FULL_LVL)) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop_ready),
        .wdata       ({rx_addr, rx_data}),
        .rdata       (rdata),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );
    assign pop_valid = ~empty;
    assign pop_addr  = rdata[W-1 -: ADDR_WIDTH];
    assign pop_data  = rdata[DATA_WIDTH-1:0];
    // full is the registered flag, so a pop on the same edge never unblocks a push.
    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_rx;
        push      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: if (req_rx) begin
                if (!full) begin
                    push      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end else if (DROP_ON_FULL != 0) begin
                    drop      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end else state_nxt = STALL;
            end
            STALL: if (!req_rx) state_nxt = IDLE;
            else if (!full) begin
                push      = 1'b1;
                ack_nxt   = 1'b1;
                state_nxt = ACK;
            end
            ACK: if (!req_rx) begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ovf_nxt = clr_ovf ? 1'b0 : overflow | drop;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ack_rx   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_rx   <= ack_nxt;
            overflow <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_ulpb_rx_fifo.sv
// tb_ulpb_rx_fifo: directed checks of ulpb_rx_fifo in stall mode (dut_a) and drop mode (dut_b).
module tb_ulpb_rx_fifo;
    import ulpb_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, clr_ovf = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, pr_a = 1'b0, pr_b = 1'b0;
    logic [7:0] rx_addr = '0;
    logic [31:0] rx_data = '0;
    logic ack_a, vld_a, full_a, af_a, ovf_a, ack_b, vld_b, full_b, af_b, ovf_b;
    logic [7:0] pa_a, pa_b;
    logic [31:0] pd_a, pd_b;
    logic [2:0] cnt_a, cnt_b;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    ulpb_rx_fifo #(.DROP_ON_FULL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_rx(req_a), .ack_rx(ack_a), .rx_addr(rx_addr), .rx_data(rx_data),
        .pop_valid(vld_a), .pop_ready(pr_a), .pop_addr(pa_a), .pop_data(pd_a), .count(cnt_a),
        .full(full_a), .almost_full(af_a), .overflow(ovf_a), .clr_ovf(clr_ovf)
    );
    ulpb_rx_fifo #(.DROP_ON_FULL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_rx(req_b), .ack_rx(ack_b), .rx_addr(rx_addr), .rx_data(rx_data),
        .pop_valid(vld_b), .pop_ready(pr_b), .pop_addr(pa_b), .pop_data(pd_b), .count(cnt_b),
        .full(full_b), .almost_full(af_b), .overflow(ovf_b), .clr_ovf(clr_ovf)
    );
    typedef struct {
        logic req, pr;
        logic [7:0] a;
        logic [31:0] d;
        logic ack, vld;
        logic [2:0] cnt;
        logic full, af;
        logic [7:0] ha;
        logic [31:0] hd;
    } vec_t;
    vec_t vq[$];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input bit b, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        rx_addr = a;
        rx_data = d;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        do begin
            tick();
            n++;
        end while (!(b ? ack_b : ack_a) && n < 10);
        chk("push_ack", 64'(b ? ack_b : ack_a), 64'h1);
        if (b) req_b = 1'b0; else req_a = 1'b0;
        tick();
        chk("push_ack_fall", 64'(b ? ack_b : ack_a), 64'h0);
    endtask
    task automatic pop(input bit b, input logic [7:0] a, input logic [31:0] d);
        chk("pop_valid", 64'(b ? vld_b : vld_a), 64'h1);
        chk("pop_addr", 64'(b ? pa_b : pa_a), 64'(a));
        chk("pop_data", 64'(b ? pd_b : pd_a), 64'(d));
        if (b) pr_b = 1'b1; else pr_a = 1'b1;
        tick();
        pr_a = 1'b0;
        pr_b = 1'b0;
    endtask
    initial begin
        bit saw;
        // single word with pop_ready held high, then fill/stall/wrap in stall mode
        vq.push_back('{1'b1, 1'b1, 8'hab, 32'habcdef12, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'hab, 32'habcdef12});
        vq.push_back('{1'b0, 1'b1, 8'hab, 32'habcdef12, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 32'h00000000});
        vq.push_back('{1'b1, 1'b0, 8'h10, 32'h21fedcba, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b0, 1'b0, 8'h10, 32'h21fedcba, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b0, 8'h11, 32'h21fedcbb, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b0, 1'b0, 8'h11, 32'h21fedcbb, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b0, 8'h12, 32'h21fedcbc, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b0, 1'b0, 8'h12, 32'h21fedcbc, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b0, 8'h13, 32'h21fedcbd, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b0, 1'b0, 8'h13, 32'h21fedcbd, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b0, 8'h14, 32'h21fedcbe, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b0, 8'h14, 32'h21fedcbe, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h10, 32'h21fedcba});
        vq.push_back('{1'b1, 1'b1, 8'h14, 32'h21fedcbe, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h11, 32'h21fedcbb});
        vq.push_back('{1'b1, 1'b0, 8'h14, 32'h21fedcbe, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h11, 32'h21fedcbb});
        vq.push_back('{1'b0, 1'b0, 8'h14, 32'h21fedcbe, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h11, 32'h21fedcbb});
        vq.push_back('{1'b1, 1'b0, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h11, 32'h21fedcbb});
        vq.push_back('{1'b1, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h12, 32'h21fedcbc});
        vq.push_back('{1'b1, 1'b0, 8'h15, 32'h21fedcbf, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h12, 32'h21fedcbc});
        vq.push_back('{1'b0, 1'b0, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h12, 32'h21fedcbc});
        vq.push_back('{1'b0, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h13, 32'h21fedcbd});
        vq.push_back('{1'b0, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h14, 32'h21fedcbe});
        vq.push_back('{1'b0, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h15, 32'h21fedcbf});
        vq.push_back('{1'b0, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h12, 32'h21fedcbc});
        vq.push_back('{1'b0, 1'b1, 8'h15, 32'h21fedcbf, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h12, 32'h21fedcbc});
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_ack", 64'(ack_a), 64'h0);
        chk("rst_valid", 64'(vld_a), 64'h0);
        chk("rst_count", 64'(cnt_a), 64'h0);
        chk("rst_full", 64'(full_a), 64'h0);
        chk("rst_af", 64'(af_a), 64'h0);
        chk("rst_ovf", 64'(ovf_b), 64'h0);
        chk("rst_head", 64'({pa_a, pd_a}), 64'h0);
        foreach (vq[i]) begin
            req_a = vq[i].req;
            pr_a = vq[i].pr;
            rx_addr = vq[i].a;
            rx_data = vq[i].d;
            tick();
            chk($sformatf("row%0d_ack", i), 64'(ack_a), 64'(vq[i].ack));
            chk($sformatf("row%0d_valid", i), 64'(vld_a), 64'(vq[i].vld));
            chk($sformatf("row%0d_count", i), 64'(cnt_a), 64'(vq[i].cnt));
            chk($sformatf("row%0d_full", i), 64'(full_a), 64'(vq[i].full));
            chk($sformatf("row%0d_af", i), 64'(af_a), 64'(vq[i].af));
            chk($sformatf("row%0d_addr", i), 64'(pa_a), 64'(vq[i].ha));
            chk($sformatf("row%0d_data", i), 64'(pd_a), 64'(vq[i].hd));
        end
        req_a = 1'b0;
        pr_a = 1'b0;
        // simultaneous push and pop at count 2
        push(0, 8'h31, 32'h31313131);
        push(0, 8'h32, 32'h32323232);
        chk("pp_count_before", 64'(cnt_a), 64'h2);
        rx_addr = 8'h33;
        rx_data = 32'h33333333;
        req_a = 1'b1;
        pr_a = 1'b1;
        tick();
        chk("pp_count", 64'(cnt_a), 64'h2);
        chk("pp_ack", 64'(ack_a), 64'h1);
        pr_a = 1'b0;
        req_a = 1'b0;
        tick();
        pop(0, 8'h32, 32'h32323232);
        pop(0, 8'h33, 32'h33333333);
        chk("pp_count_after", 64'(cnt_a), 64'h0);
        // stall abandoned by the node
        push(0, 8'h41, 32'h41414141);
        push(0, 8'h42, 32'h42424242);
        push(0, 8'h43, 32'h43434343);
        push(0, 8'h44, 32'h44444444);
        chk("ab_full", 64'(full_a), 64'h1);
        rx_addr = 8'h45;
        rx_data = 32'h45454545;
        req_a = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (ack_a) saw = 1'b1;
        end
        chk("ab_no_ack", 64'(saw), 64'h0);
        req_a = 1'b0;
        tick();
        chk("ab_state", 64'(dut_a.state), 64'(IDLE));
        chk("ab_count", 64'(cnt_a), 64'h4);
        tick();
        chk("ab_ack", 64'(ack_a), 64'h0);
        pop(0, 8'h41, 32'h41414141);
        pop(0, 8'h42, 32'h42424242);
        pop(0, 8'h43, 32'h43434343);
        pop(0, 8'h44, 32'h44444444);
        chk("ab_empty", 64'(vld_a), 64'h0);
        // drop mode on a full FIFO, then clear and clear-vs-drop priority
        push(1, 8'h51, 32'h51515151);
        push(1, 8'h52, 32'h52525252);
        push(1, 8'h53, 32'h53535353);
        push(1, 8'h54, 32'h54545454);
        chk("dr_full", 64'(full_b), 64'h1);
        chk("dr_ovf_pre", 64'(ovf_b), 64'h0);
        push(1, 8'haa, 32'haabbccdd);
        chk("dr_ovf", 64'(ovf_b), 64'h1);
        chk("dr_count", 64'(cnt_b), 64'h4);
        chk("dr_head", 64'({pa_b, pd_b}), 64'h5151515151);
        tick();
        chk("dr_sticky", 64'(ovf_b), 64'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("dr_clr", 64'(ovf_b), 64'h0);
        rx_addr = 8'hcc;
        rx_data = 32'hcccccccc;
        req_b = 1'b1;
        clr_ovf = 1'b1;
        tick();
        chk("dr_clr_prio_ack", 64'(ack_b), 64'h1);
        chk("dr_clr_prio_ovf", 64'(ovf_b), 64'h0);
        clr_ovf = 1'b0;
        req_b = 1'b0;
        tick();
        chk("dr_ovf_after", 64'(ovf_b), 64'h0);
        pop(1, 8'h51, 32'h51515151);
        pop(1, 8'h52, 32'h52525252);
        pop(1, 8'h53, 32'h53535353);
        pop(1, 8'h54, 32'h54545454);
        chk("dr_empty", 64'(cnt_b), 64'h0);
        chk("stall_mode_ovf", 64'(ovf_a), 64'h0);
        // asynchronous reset while in ACK with three entries
        push(0, 8'h61, 32'h61616161);
        push(0, 8'h62, 32'h62626262);
        rx_addr = 8'h63;
        rx_data = 32'h63636363;
        req_a = 1'b1;
        tick();
        chk("rs_ack", 64'(ack_a), 64'h1);
        chk("rs_count", 64'(cnt_a), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_ack", 64'(ack_a), 64'h0);
        chk("rs_async_count", 64'(cnt_a), 64'h0);
        chk("rs_async_valid", 64'(vld_a), 64'h0);
        req_a = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        push(0, 8'h77, 32'h55667788);
        chk("rs_new_count", 64'(cnt_a), 64'h1);
        chk("rs_new_head", 64'({pa_a, pd_a}), 64'h7755667788);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
